vdp_bus_port: RTL and testbench
===============================

VDP_BUS_PORT -- requirements
Module: vdp_bus_port

Interface
REQ-001 SHALL have parameter BASE, default 16'hFFF0, the register window base; the window is BASE..BASE+15, 16-aligned.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the VRAM write FIFO depth; it is a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port address, input, 16: CPU bus address.
REQ-006 SHALL have port dataIn, input, 8: CPU write data.
REQ-007 SHALL have port write, input, 1: one-cycle CPU write strobe.
REQ-008 SHALL have port read, input, 1: one-cycle CPU read strobe.
REQ-009 SHALL have port dataOut, output, 8: registered read data.
REQ-010 SHALL have port selected, output, 1: registered; high the cycle after a read hits the window.
REQ-011 SHALL have port vSync, input, 1: active-high VDP vertical sync.
REQ-012 SHALL have ports vramReq, output, 1; vramAddr, output, 14; vramData, output, 8: the FIFO head toward the VDP.
REQ-013 SHALL have port vramAck, input, 1: the VDP consumes the head entry.
REQ-014 SHALL have ports ctrl, output, 8; scrollX, output, 8; scrollY, output, 8: active VDP registers.
REQ-015 SHALL have port irq, output, 1: vertical-blank interrupt.

Function
REQ-016 SHALL map registers as offsets from BASE:
- 0: addrLo R/W.
- 1: addrHi R/W; bits [5:0] are used, and bits [7:6] read 0.
- 2: data port; a write enqueues a VRAM write, and a read returns 0.
- 3: incr R/W.
- 4: ctrl shadow R/W.
- 5: scrollX shadow R/W.
- 6: scrollY shadow R/W.
- 7: status, read-only.
- 8-15: read 0; writes are ignored.
REQ-017 SHALL ignore accesses outside the window; selected stays 0 and dataOut holds its previous value.
REQ-018 SHALL deliver read data on dataOut exactly 1 cycle after the read strobe.
REQ-019 SHALL push {addr, dataIn} on a data-port write, then set addr = (addr + incr) mod 2^14; 3FFF+1 wraps to 0000.
REQ-020 SHALL drop a data-port write when the FIFO is full and no pop occurs that cycle; in that case it sets the sticky overflow flag and does not increment addr.
REQ-021 SHALL accept a push and a pop in the same cycle at any occupancy, including full; the count is then unchanged.
REQ-022 SHALL hold vramReq high whenever the FIFO is non-empty, with vramAddr/vramData showing the oldest entry.
REQ-023 SHALL pop the head on any cycle where vramReq and vramAck are both high.
REQ-024 SHALL ignore vramAck while the FIFO is empty.
REQ-025 SHALL detect a vSync rising edge as vSync high in the current cycle with the registered previous value low.
REQ-026 SHALL, on a vSync rising edge, set the vblank flag and commit the shadow ctrl/scrollX/scrollY values to the active outputs (subject to REQ-036/037).
REQ-027 SHALL format status as:
- bit7: vblank.
- bit6: FIFO full.
- bit5: FIFO empty.
- bit4: overflow.
- bits [3:0]: 0.
REQ-028 SHALL return the pre-cycle status value on a status read, then clear vblank and overflow.
REQ-029 SHALL keep a flag set when a set event and a status read occur in the same cycle; the read returns the old value.
REQ-030 SHALL compute irq = vblank AND active ctrl bit1, registered; ctrl bit0 means display enable and is passed through only.

Reset
REQ-031 SHALL, on reset, clear the FIFO and set addr = 0, incr = 1, shadow and active ctrl/scrollX/scrollY = 0, vblank = 0, overflow = 0.
REQ-032 SHALL, on reset, drive dataOut = 0, selected = 0, vramReq = 0, irq = 0.
REQ-033 SHALL reset the vSync previous-value register to 1, so vSync held high across reset release is not an edge.
REQ-034 SHALL let reset asserted mid-operation discard pending FIFO entries; no vramReq is issued the following cycle.
REQ-035 SHALL give reset priority over all simultaneous bus and vSync events.

Configuration
REQ-036 SHALL, with VDP_BUS_PORT_SHADOW_EN defined, commit ctrl/scrollX/scrollY writes to the active outputs only on a vSync rising edge.
REQ-037 SHALL, without VDP_BUS_PORT_SHADOW_EN, update the active outputs the cycle after the write; the vSync edge then sets only vblank.

Verification
REQ-038 SHALL cover auto-increment: write FFF0=FE, FFF1=3F, FFF3=02, then FFF2=AA and FFF2=BB with vramAck=1 -> VRAM writes 3FFE:AA then 0000:BB; FFF0 reads 02.
REQ-039 SHALL cover overflow: with vramAck=0, five FFF2 writes -> four entries held, the fifth dropped; a status read returns 0x50, then a second read returns 0x40.
REQ-040 SHALL cover full push+pop: FIFO full, data-port write with vramAck=1 in the same cycle -> write accepted, count stays 4, no overflow.
REQ-041 SHALL cover shadow commit with VDP_BUS_PORT_SHADOW_EN: write FFF5=10 -> scrollX stays 00 until the vSync rising edge, then reads 10 on the next cycle; without the macro, scrollX=10 the cycle after the write.
REQ-042 SHALL cover the interrupt: ctrl=02 committed, vSync pulse -> irq=1; status read returns 0xA0 and irq=0 on the following cycle; a read coinciding with the next edge keeps vblank=1.
REQ-043 SHALL cover reset mid-stream: 3 queued entries and reset asserted -> vramReq=0, addr=0000, incr=1, status reads 0x20.

Source files
------------

// File: rtl/vdp_bus_port_if.sv
// CPU-side register bus, VRAM write channel and active VDP register outputs
// of the vdp_bus_port block, bundled as one interface.
interface vdp_bus_port_if;
    logic [15:0] address;
    logic [7:0]  dataIn;
    logic        write;
    logic        read;
    logic [7:0]  dataOut;
    logic        selected;
    logic        vSync;
    logic        vramReq;
    logic [13:0] vramAddr;
    logic [7:0]  vramData;
    logic        vramAck;
    logic [7:0]  ctrl;
    logic [7:0]  scrollX;
    logic [7:0]  scrollY;
    logic        irq;

    modport master (
        output address, dataIn, write, read, vSync, vramAck,
        input  dataOut, selected, vramReq, vramAddr, vramData,
               ctrl, scrollX, scrollY, irq
    );

    modport slave (
        input  address, dataIn, write, read, vSync, vramAck,
        output dataOut, selected, vramReq, vramAddr, vramData,
               ctrl, scrollX, scrollY, irq
    );
endinterface

// File: rtl/vdp_bus_port.sv
// CPU register window for a VDP: auto-incrementing VRAM write FIFO, status/vblank, scroll/ctrl.
// Define VDP_BUS_PORT_SHADOW_EN to latch ctrl/scrollX/scrollY into the active outputs only on vSync.
module vdp_bus_port #(
    parameter logic [15:0] BASE       = 16'hFFF0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    vdp_bus_port_if.slave  bus
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [21:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic [13:0] addr;
    logic [7:0]  incr;
    logic [7:0]  ctrl_sh, scx_sh, scy_sh;
    logic        vblank, overflow, vsync_prev;

    logic        hit, wr_hit, rd_hit;
    logic [3:0]  off;
    logic        full, empty, pop, push_req, push, drop, vsync_edge, status_rd;
    logic        vblank_n;
    logic [7:0]  ctrl_n, status, rd_data;

    assign hit        = (bus.address[15:4] == BASE[15:4]);
    assign off        = bus.address[3:0];
    assign wr_hit     = bus.write && hit;
    assign rd_hit     = bus.read && hit;

    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);
    assign pop        = !empty && bus.vramAck;
    assign push_req   = wr_hit && (off == 4'd2);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push       = push_req && (!full || pop);
    assign drop       = push_req && !push;

    assign vsync_edge = bus.vSync && !vsync_prev;
    assign status_rd  = rd_hit && (off == 4'd7);
    assign status     = {vblank, full, empty, overflow, 4'b0000};

    assign bus.vramReq                  = !empty;
    assign {bus.vramAddr, bus.vramData} = mem[rd_ptr];

    always_comb begin
        rd_data = '0;
        case (off)
            4'd0:    rd_data = addr[7:0];
            4'd1:    rd_data = {2'b00, addr[13:8]};
            4'd3:    rd_data = incr;
            4'd4:    rd_data = ctrl_sh;
            4'd5:    rd_data = scx_sh;
            4'd6:    rd_data = scy_sh;
            4'd7:    rd_data = status;
            default: rd_data = '0;
        endcase
    end

    // Next active ctrl and vblank, shared by their registers and the registered irq.
    always_comb begin
        ctrl_n = bus.ctrl;
`ifdef VDP_BUS_PORT_SHADOW_EN
        if (vsync_edge) ctrl_n = ctrl_sh;
`else
        if (wr_hit && (off == 4'd4)) ctrl_n = bus.dataIn;
`endif
        vblank_n = vblank;
        if (vsync_edge)     vblank_n = 1'b1;
        else if (status_rd) vblank_n = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {addr, bus.dataIn};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            addr         <= '0;
            incr         <= 8'd1;
            ctrl_sh      <= '0;
            scx_sh       <= '0;
            scy_sh       <= '0;
            bus.ctrl     <= '0;
            bus.scrollX  <= '0;
            bus.scrollY  <= '0;
            vblank       <= 1'b0;
            overflow     <= 1'b0;
            vsync_prev   <= 1'b1;
            bus.dataOut  <= '0;
            bus.selected <= 1'b0;
            bus.irq      <= 1'b0;
        end else begin
            vsync_prev   <= bus.vSync;
            bus.selected <= rd_hit;
            if (rd_hit) bus.dataOut <= rd_data;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                addr   <= addr + 14'(incr);
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;

            if (wr_hit) begin
                case (off)
                    4'd0:    addr[7:0]  <= bus.dataIn;
                    4'd1:    addr[13:8] <= bus.dataIn[5:0];
                    4'd3:    incr       <= bus.dataIn;
                    4'd4:    ctrl_sh    <= bus.dataIn;
                    4'd5:    scx_sh     <= bus.dataIn;
                    4'd6:    scy_sh     <= bus.dataIn;
                    default: ;
                endcase
            end

`ifdef VDP_BUS_PORT_SHADOW_EN
            if (vsync_edge) begin
                bus.scrollX <= scx_sh;
                bus.scrollY <= scy_sh;
            end
`else
            if (wr_hit && (off == 4'd5)) bus.scrollX <= bus.dataIn;
            if (wr_hit && (off == 4'd6)) bus.scrollY <= bus.dataIn;
`endif
            bus.ctrl <= ctrl_n;
            vblank   <= vblank_n;
            bus.irq  <= vblank_n && ctrl_n[1];

            // Setting wins over the clear-on-read when both land in one cycle.
            if (drop)           overflow <= 1'b1;
            else if (status_rd) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vdp_bus_port.sv
// Bench for vdp_bus_port: register table, VRAM write scoreboard and multi-cycle corner sequences.
module tb_vdp_bus_port;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vdp_bus_port_if bus();

    vdp_bus_port #(.BASE(16'hFFF0), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] off;
        logic       wr;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    logic [21:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus.address = a;
        bus.dataIn  = d;
        bus.write   = 1'b1;
        tick();
        bus.write   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        bus.address = a;
        bus.read    = 1'b1;
        tick();
        bus.read    = 1'b0;
        d = bus.dataOut;
    endtask

    task automatic rd_check(input string name, input logic [15:0] a, input logic [7:0] e);
        logic [7:0] d;
        rd(a, d);
        check(name, 32'(d), 32'(e));
        check({name, "_sel"}, 32'(bus.selected), 32'h1);
    endtask

    // Data-port write; an accepted one is expected later on the VRAM channel at address ea.
    task automatic dwr(input logic [7:0] d, input logic [13:0] ea, input bit acc);
        if (acc) exp_q.push_back({ea, d});
        wr(16'hFFF2, d);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic vsync_pulse();
        bus.vSync = 1'b1;
        tick();
        bus.vSync = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && bus.vramReq && bus.vramAck) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL vram_unexpected: got %h:%h, want no write", bus.vramAddr, bus.vramData);
            end else begin
                check("vram_write", 32'({bus.vramAddr, bus.vramData}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        vec_t tbl[12];
        logic [7:0] d;

        tbl[0]  = '{4'h0, 1'b1, 8'h5A, 8'h5A};
        tbl[1]  = '{4'h1, 1'b1, 8'hFF, 8'h3F};
        tbl[2]  = '{4'h3, 1'b1, 8'h07, 8'h07};
        tbl[3]  = '{4'h4, 1'b1, 8'h81, 8'h81};
        tbl[4]  = '{4'h5, 1'b1, 8'h33, 8'h33};
        tbl[5]  = '{4'h6, 1'b1, 8'hC4, 8'hC4};
        tbl[6]  = '{4'h8, 1'b1, 8'hAA, 8'h00};
        tbl[7]  = '{4'hF, 1'b1, 8'h55, 8'h00};
        tbl[8]  = '{4'h2, 1'b0, 8'h00, 8'h00};
        tbl[9]  = '{4'h7, 1'b0, 8'h00, 8'h20};
        tbl[10] = '{4'h7, 1'b1, 8'hFF, 8'h20};
        tbl[11] = '{4'h0, 1'b0, 8'h00, 8'h5A};

        bus.address = 16'h0000;
        bus.dataIn  = 8'h00;
        bus.write   = 1'b0;
        bus.read    = 1'b0;
        bus.vSync   = 1'b1;
        bus.vramAck = 1'b0;

        // vSync held high across reset release must not count as an edge.
        tick();
        tick();
        reset = 1'b0;
        check("rst_dataOut", 32'(bus.dataOut), 32'h0);
        check("rst_selected", 32'(bus.selected), 32'h0);
        check("rst_vramReq", 32'(bus.vramReq), 32'h0);
        check("rst_irq", 32'(bus.irq), 32'h0);
        check("rst_ctrl", 32'(bus.ctrl), 32'h0);
        check("rst_scrollX", 32'(bus.scrollX), 32'h0);
        tick();
        bus.vSync = 1'b0;
        rd_check("rst_status_no_edge", 16'hFFF7, 8'h20);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].wr) wr({12'hFFF, tbl[i].off}, tbl[i].wd);
            rd_check($sformatf("reg_%0d", i), {12'hFFF, tbl[i].off}, tbl[i].exp);
        end
`ifdef VDP_BUS_PORT_SHADOW_EN
        check("tbl_scrollX", 32'(bus.scrollX), 32'h00);
        check("tbl_ctrl", 32'(bus.ctrl), 32'h00);
`else
        check("tbl_scrollX", 32'(bus.scrollX), 32'h33);
        check("tbl_ctrl", 32'(bus.ctrl), 32'h81);
        check("tbl_scrollY", 32'(bus.scrollY), 32'hC4);
`endif

        // Out-of-window accesses: no select, dataOut holds, writes ignored.
        rd(16'hFFE0, d);
        check("oow_dataOut", 32'(d), 32'h5A);
        check("oow_selected", 32'(bus.selected), 32'h0);
        wr(16'h0003, 8'h99);
        rd_check("oow_write_ignored", 16'hFFF3, 8'h07);

        // Auto-increment with wrap at 3FFF.
        do_reset();
        bus.vramAck = 1'b1;
        wr(16'hFFF0, 8'hFE);
        wr(16'hFFF1, 8'h3F);
        wr(16'hFFF3, 8'h02);
        dwr(8'hAA, 14'h3FFE, 1'b1);
        dwr(8'hBB, 14'h0000, 1'b1);
        tick();
        tick();
        check("incr_drained", 32'(exp_q.size()), 32'h0);
        rd_check("incr_addrLo", 16'hFFF0, 8'h02);
        rd_check("incr_addrHi", 16'hFFF1, 8'h00);
        bus.vramAck = 1'b0;

        // Overflow: fifth write dropped, sticky flag cleared on read.
        do_reset();
        dwr(8'h11, 14'h0000, 1'b1);
        dwr(8'h22, 14'h0001, 1'b1);
        dwr(8'h33, 14'h0002, 1'b1);
        dwr(8'h44, 14'h0003, 1'b1);
        dwr(8'h55, 14'h0004, 1'b0);
        check("ovf_vramReq", 32'(bus.vramReq), 32'h1);
        check("ovf_head", 32'({bus.vramAddr, bus.vramData}), 32'({14'h0000, 8'h11}));
        rd_check("ovf_status1", 16'hFFF7, 8'h50);
        rd_check("ovf_status2", 16'hFFF7, 8'h40);
        rd_check("ovf_addr_held", 16'hFFF0, 8'h04);

        // Full FIFO: push and pop in the same cycle.
        bus.vramAck = 1'b1;
        dwr(8'h66, 14'h0004, 1'b1);
        bus.vramAck = 1'b0;
        rd_check("fullpp_status", 16'hFFF7, 8'h40);
        check("fullpp_head", 32'({bus.vramAddr, bus.vramData}), 32'({14'h0001, 8'h22}));
        bus.vramAck = 1'b1;
        repeat (6) tick();
        bus.vramAck = 1'b0;
        check("fullpp_drained", 32'(exp_q.size()), 32'h0);
        rd_check("fullpp_status_empty", 16'hFFF7, 8'h20);

        // Scroll commit timing.
        do_reset();
        wr(16'hFFF5, 8'h10);
`ifdef VDP_BUS_PORT_SHADOW_EN
        check("shadow_scrollX_pre", 32'(bus.scrollX), 32'h00);
`else
        check("shadow_scrollX_pre", 32'(bus.scrollX), 32'h10);
`endif
        vsync_pulse();
        check("shadow_scrollX_post", 32'(bus.scrollX), 32'h10);
        rd_check("vsync_status1", 16'hFFF7, 8'hA0);
        rd_check("vsync_status2", 16'hFFF7, 8'h20);

        // Interrupt and read/edge collision.
        do_reset();
        wr(16'hFFF4, 8'h02);
        vsync_pulse();
        check("irq_set", 32'(bus.irq), 32'h1);
        check("irq_ctrl", 32'(bus.ctrl), 32'h02);
        rd_check("irq_status", 16'hFFF7, 8'hA0);
        check("irq_cleared", 32'(bus.irq), 32'h0);
        bus.vSync   = 1'b1;
        bus.address = 16'hFFF7;
        bus.read    = 1'b1;
        tick();
        bus.read    = 1'b0;
        bus.vSync   = 1'b0;
        check("collide_status", 32'(bus.dataOut), 32'h20);
        check("collide_irq", 32'(bus.irq), 32'h1);
        rd_check("collide_vblank_kept", 16'hFFF7, 8'hA0);

        // Reset mid-stream discards queued entries and wins over a same-cycle write and vSync edge.
        do_reset();
        wr(16'hFFF0, 8'h10);
        wr(16'hFFF3, 8'h05);
        dwr(8'hA1, 14'h0010, 1'b1);
        dwr(8'hA2, 14'h0015, 1'b1);
        dwr(8'hA3, 14'h001A, 1'b1);
        check("mid_vramReq_pre", 32'(bus.vramReq), 32'h1);
        reset       = 1'b1;
        bus.address = 16'hFFF0;
        bus.dataIn  = 8'h77;
        bus.write   = 1'b1;
        bus.vSync   = 1'b1;
        tick();
        bus.write   = 1'b0;
        bus.vSync   = 1'b0;
        check("mid_vramReq", 32'(bus.vramReq), 32'h0);
        reset = 1'b0;
        exp_q.delete();
        check("mid_irq", 32'(bus.irq), 32'h0);
        check("mid_dataOut", 32'(bus.dataOut), 32'h0);
        tick();
        check("mid_vramReq_after", 32'(bus.vramReq), 32'h0);
        rd_check("mid_addrLo", 16'hFFF0, 8'h00);
        rd_check("mid_addrHi", 16'hFFF1, 8'h00);
        rd_check("mid_incr", 16'hFFF3, 8'h01);
        rd_check("mid_status", 16'hFFF7, 8'h20);

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
